mac_seq: RTL and testbench
==========================

Name: mac_seq

Overview:
- Sequential, parametrised multiply-accumulate engine for the fc_layer datapath. It computes M dot products of length K, one vector element per accepted beat.
- Each beat carries one shared activation x and M per-lane weights w[m]. Each lane adds a per-lane bias S0[m], sampled on the first beat.
- Optional ReLU on the result.
- Valid/ready handshakes on input and output, so the block slots between a weight/activation streamer and the next layer.

Parameters:
- N, 8, input bit-width of x and w (signed two's complement).
- K, 3, vector dimension (beats per dot product); K >= 1.
- M, 2, number of parallel output lanes (neurons).
- L, 2*N+$clog2(K)+1, accumulator/output width; bias width is also L.
- RELU, 0, 1 = clamp negative results to 0 at output; 0 = pass through.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- x  in  N  signed activation element, shared by all lanes.
- w  in  M*N  signed weights; lane m occupies bits [m*N +: N].
- S0  in  M*L  signed biases; lane m occupies [m*L +: L]; sampled only on the first beat of a vector.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts the result.
- S  out  M*L  signed results; lane m occupies [m*L +: L].
- busy  out  1  a vector is in progress (state ACC or HOLD).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, beat count=0, all accumulators=0, S=0, out_valid=0, busy=0. in_ready goes to its IDLE value 1 once rst releases; it reads 0 while rst=0.
- Beat accepted = in_valid & in_ready at a rising clk edge.
- FSM states IDLE, ACC, HOLD:
  - IDLE: in_ready=1, out_valid=0, busy=0. On accept: acc[m] <= S0[m] + sext(x*w[m]), count <= 1. Next state is ACC if K>1, HOLD if K==1.
  - ACC: in_ready=1, busy=1. On accept: acc[m] <= acc[m] + sext(x*w[m]), count <= count+1. On the accept that makes count==K, go to HOLD. in_valid=0 leaves all state unchanged (bubble).
  - HOLD: in_ready=0, out_valid=1, busy=1. S holds the final values. When out_ready=1: count <= 0, go to IDLE; out_valid drops next cycle.
- Latency: out_valid rises the cycle after the K-th beat is accepted. Throughput is at most one vector per K+1 cycles.
- Arithmetic:
  - Full-precision signed N x N -> 2N product, sign-extended to L.
  - Accumulation wraps modulo 2^L; no saturation.
  - The default L cannot overflow with a zero bias. A nonzero bias may wrap.
- Output register:
  - S is registered and driven from acc. It is updated only on the HOLD entry edge.
  - With RELU=1, a lane whose sign bit is 1 outputs 0; acc itself is unaffected.
  - S holds its value through IDLE/ACC of the next vector until the next HOLD entry.
- Backpressure: S and out_valid are stable while out_valid=1 and out_ready=0, for any number of cycles.
- in_valid in HOLD is ignored; no beat is consumed.
- out_ready outside HOLD has no effect.
- Reset mid-vector discards partial sums. The next accepted beat is treated as a first beat and samples S0.

Decomposition:
- Package mac_pkg:
  - state enum mac_state_t {IDLE, ACC, HOLD}.
  - function acc_width(N,K) returning 2*N+$clog2(K)+1.
  - function relu(value, width) clamp helper.
- Sub-module mac_lane (one per lane, generate loop):
  - Contains the signed multiplier, sign extension, accumulator register and first-beat bias mux.
  - Control inputs from the parent FSM: load_first, acc_en.
- The parent holds the FSM, beat counter ($clog2(K+1) bits), handshakes and output/ReLU register.

Test Plan:
- Basic (N=8,K=3,M=2,RELU=0), zero bias: x=1,2,3; w0=4,5,6; w1=-1,-1,-1, back-to-back -> out_valid one cycle after 3rd beat; S lane0=32, lane1=-6.
- ReLU and bias: same vectors with RELU=1, S0 lane0=-40, lane1=10 -> lane0 acc=-8 outputs 0; lane1 outputs 4.
- Extremes: x=-128, w=-128 for all 3 beats -> lane = 49152, no wrap. x=-128, w=127 -> lane = -48768.
- Bubbles and backpressure:
  - in_valid toggled 1,0,0,1,0,1 -> count advances only on valid beats; result identical to the basic case.
  - out_ready low for 5 cycles -> in_ready=0, S/out_valid stable throughout, then one-cycle handoff back to IDLE.
- Reset mid-operation: assert rst after 2 beats -> out_valid=0, busy=0 immediately. A new 3-beat vector with bias 7 yields 7+dot only, with no stale partial sum.
- K=1 configuration: a single beat x=5, w=-3, bias 2 -> HOLD next cycle, S=-13.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the mac_seq multiply-accumulate engine.
package mac_pkg;

    // Vector progress: waiting for a first beat, collecting beats, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } mac_state_t;

    // Widest lane value the ReLU helper handles.
    localparam int RELU_MAX_W = 64;

    // Accumulator width that holds K full-precision products plus a sign guard bit.
    function automatic int acc_width(input int n, input int k);
        return 2 * n + $clog2(k) + 1;
    endfunction

    // Clamp a value to zero when its sign bit (bit width-1) is set.
    function automatic logic [RELU_MAX_W-1:0] relu(input logic [RELU_MAX_W-1:0] value,
                                                    input int                     width);
        logic [RELU_MAX_W-1:0] res;
        res = value;
        if (value[width-1]) begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One neuron lane: signed multiplier, sign extension, first-beat bias mux, accumulator.
module mac_lane #(
    parameter int N = 8,
    parameter int L = 19
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_first_i,
    input  logic                acc_en_i,
    input  logic signed [N-1:0] x_i,
    input  logic signed [N-1:0] w_i,
    input  logic signed [L-1:0] bias_i,
    output logic signed [L-1:0] acc_d_o
);

    logic signed [2*N-1:0] prod;
    logic signed [L-1:0]   prod_ext;
    logic signed [L-1:0]   acc_q;
    logic signed [L-1:0]   acc_d;

    // Full-precision product, sign-extended to accumulator width.
    assign prod     = x_i * w_i;
    assign prod_ext = L'(prod);

    // First beat starts from the bias; later beats add onto the running sum (wraps mod 2^L).
    always_comb begin
        acc_d = load_first_i ? (bias_i + prod_ext) : (acc_q + prod_ext);
    end

    // Accumulator register, advanced only on accepted beats.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= acc_d;
        end
    end

    // The parent captures the post-beat value on the edge that enters HOLD.
    assign acc_d_o = acc_d;

endmodule

// File: rtl/mac_seq.sv
// Sequential M-lane multiply-accumulate engine with valid/ready handshakes and optional ReLU.
module mac_seq
    import mac_pkg::*;
#(
    parameter int N    = 8,
    parameter int K    = 3,
    parameter int M    = 2,
    parameter int L    = acc_width(N, K),
    parameter bit RELU = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] x,
    input  logic [M*N-1:0]      w,
    input  logic [M*L-1:0]      S0,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [M*L-1:0]      S,
    output logic                busy
);

    localparam int CW = $clog2(K + 1);

    mac_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [M*L-1:0]        s_q, s_d;
    logic signed [L-1:0]   lane_next [M];
    logic [RELU_MAX_W-1:0] lane_wide;
    logic                  accept;
    logic                  load_first;
    logic                  hold_entry;

    assign accept     = in_valid & in_ready;
    assign load_first = accept & (state_q == IDLE);
    assign hold_entry = (state_q != HOLD) & (state_d == HOLD);

    for (genvar m = 0; m < M; m++) begin : g_lane
        mac_lane #(
            .N(N),
            .L(L)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .load_first_i (load_first),
            .acc_en_i     (accept),
            .x_i          (x),
            .w_i          (w[m*N +: N]),
            .bias_i       (S0[m*L +: L]),
            .acc_d_o      (lane_next[m])
        );
    end

    // State, beat counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
        end
    end

    // Next state and beat count: count accepted beats, hold until the consumer takes the result.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = CW'(1);
                    state_d = (K == 1) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(K - 1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result capture: load the final lane sums (optionally clamped) only when entering HOLD.
    always_comb begin
        s_d       = s_q;
        lane_wide = '0;
        if (hold_entry) begin
            for (int m = 0; m < M; m++) begin
                lane_wide = RELU_MAX_W'(lane_next[m]);
                if (RELU) begin
                    lane_wide = relu(lane_wide, L);
                end
                s_d[m*L +: L] = lane_wide[L-1:0];
            end
        end
    end

    // Handshake outputs decoded from the current state; in_ready stays low while in reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = rst;
            end
            ACC: begin
                in_ready = rst;
                busy     = 1'b1;
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign S = s_q;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: a K=3 pass-through instance, a K=3 ReLU instance and a
// K=1 instance share one stimulus stream and are compared every cycle against a
// beat-list model, with literal expectations for the hand-worked vectors.
module tb_mac_seq;

    localparam int N  = 8;
    localparam int K  = 3;
    localparam int M  = 2;
    localparam int L3 = 19;  // 2*8 + clog2(3) + 1
    localparam int L1 = 17;  // 2*8 + clog2(1) + 1

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                in_valid;
    logic                out_ready;
    logic signed [N-1:0] x_in;
    logic signed [N-1:0] w_in [M];
    longint              b3 [M];
    longint              b1 [M];

    logic [M*N-1:0]  w_bus;
    logic [M*L3-1:0] s0_3;
    logic [M*L1-1:0] s0_1;

    always_comb begin
        w_bus = '0;
        s0_3  = '0;
        s0_1  = '0;
        for (int m = 0; m < M; m++) begin
            w_bus[m*N +: N]   = w_in[m];
            s0_3[m*L3 +: L3]  = b3[m][L3-1:0];
            s0_1[m*L1 +: L1]  = b1[m][L1-1:0];
        end
    end

    logic            rdy3, ov3, busy3;
    logic [M*L3-1:0] s3;
    logic            rdyr, ovr, busyr;
    logic [M*L3-1:0] sr;
    logic            rdy1, ov1, busy1;
    logic [M*L1-1:0] s1;

    mac_seq #(.N(N), .K(K), .M(M), .RELU(1'b0)) dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(rdy3), .x(x_in), .w(w_bus),
        .S0(s0_3), .out_valid(ov3), .out_ready(out_ready), .S(s3), .busy(busy3)
    );

    mac_seq #(.N(N), .K(K), .M(M), .RELU(1'b1)) dut_r (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(rdyr), .x(x_in), .w(w_bus),
        .S0(s0_3), .out_valid(ovr), .out_ready(out_ready), .S(sr), .busy(busyr)
    );

    mac_seq #(.N(N), .K(1), .M(M), .RELU(1'b0)) dut_k1 (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(rdy1), .x(x_in), .w(w_bus),
        .S0(s0_1), .out_valid(ov1), .out_ready(out_ready), .S(s1), .busy(busy1)
    );

    logic signed [L3-1:0] s3_l [M];
    logic signed [L3-1:0] sr_l [M];
    logic signed [L1-1:0] s1_l [M];

    always_comb begin
        for (int m = 0; m < M; m++) begin
            s3_l[m] = s3[m*L3 +: L3];
            sr_l[m] = sr[m*L3 +: L3];
            s1_l[m] = s1[m*L1 +: L1];
        end
    end

    // ---------------- checking ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model 0 serves both K=3 instances, model 1 the K=1 instance.
    int     beats [2];
    bit     hold  [2];
    longint acc   [2][M];
    longint res   [2][M];

    function automatic longint wrap(input longint v, input int l);
        return (v <<< (64 - l)) >>> (64 - l);
    endfunction

    function automatic longint relu_of(input longint v);
        return (v < 0) ? 64'sd0 : v;
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            beats[id] = 0;
            hold[id]  = 1'b0;
            for (int m = 0; m < M; m++) begin
                acc[id][m] = 0;
                res[id][m] = 0;
            end
        end
    endtask

    task automatic model_step(input int id, input int k, input int l);
        longint p;
        longint bias;
        if (hold[id]) begin
            if (out_ready) begin
                hold[id]  = 1'b0;
                beats[id] = 0;
            end
        end else if (in_valid) begin
            for (int m = 0; m < M; m++) begin
                p    = longint'(x_in) * longint'(w_in[m]);
                bias = (id == 0) ? b3[m] : b1[m];
                acc[id][m] = (beats[id] == 0) ? wrap(bias + p, l) : wrap(acc[id][m] + p, l);
            end
            beats[id]++;
            if (beats[id] == k) begin
                hold[id] = 1'b1;
                for (int m = 0; m < M; m++) begin
                    res[id][m] = acc[id][m];
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, K, L3);
            model_step(1, 1, L1);
        end
    end

    // Every-cycle compare of all three instances against the model.
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("dut_in_ready",  rdy3,  rst_n && !hold[0]);
            check("dut_out_valid", ov3,   hold[0]);
            check("dut_busy",      busy3, hold[0] || beats[0] > 0);
            check("rl_in_ready",   rdyr,  rst_n && !hold[0]);
            check("rl_out_valid",  ovr,   hold[0]);
            check("rl_busy",       busyr, hold[0] || beats[0] > 0);
            check("k1_in_ready",   rdy1,  rst_n && !hold[1]);
            check("k1_out_valid",  ov1,   hold[1]);
            check("k1_busy",       busy1, hold[1] || beats[1] > 0);
            for (int m = 0; m < M; m++) begin
                check($sformatf("dut_S%0d", m), s3_l[m], res[0][m]);
                check($sformatf("rl_S%0d", m),  sr_l[m], relu_of(res[0][m]));
                check($sformatf("k1_S%0d", m),  s1_l[m], res[1][m]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int xv, input int w0, input int w1);
        x_in     = N'(xv);
        w_in[0]  = N'(w0);
        w_in[1]  = N'(w1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after the final beat: result must be presented on this cycle.
    task automatic expect_hold(input string tag, input longint e0, input longint e1,
                               input longint r0, input longint r1);
        @(negedge clk);
        check({tag, "_out_valid"}, ov3, 1);
        check({tag, "_in_ready"},  rdy3, 0);
        check({tag, "_S0"},        s3_l[0], e0);
        check({tag, "_S1"},        s3_l[1], e1);
        check({tag, "_relu_S0"},   sr_l[0], r0);
        check({tag, "_relu_S1"},   sr_l[1], r1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        w_in      = '{default: '0};
        b3        = '{default: 0};
        b1        = '{default: 0};
        model_reset();

        // Reset state.
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_S0",        s3_l[0], 0);
        check("rst_out_valid", ov3, 0);
        check("rst_in_ready",  rdy3, 0);
        check("rst_busy",      busy3, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Basic dot product, zero bias, back-to-back beats.
        beat(1, 4, -1);
        beat(2, 5, -1);
        beat(3, 6, -1);
        expect_hold("basic", 32, -6, 32, 0);

        // Bias sampled on the first beat; ReLU clamps the negative lane.
        b3 = '{-40, 10};
        beat(1, 4, -1);
        b3 = '{0, 0};
        beat(2, 5, -1);
        beat(3, 6, -1);
        expect_hold("bias", -8, 4, 0, 4);

        // Extreme operands.
        beat(-128, -128, 127);
        beat(-128, -128, 127);
        beat(-128, -128, 127);
        expect_hold("ext", 49152, -48768, 49152, 0);

        // Bubbles: in_valid pattern 1,0,0,1,0,1; bias changes after the first beat are ignored.
        beat(1, 4, -1);
        b3 = '{99, 99};
        idle(2);
        beat(2, 5, -1);
        idle(1);
        beat(3, 6, -1);
        expect_hold("bubble", 32, -6, 32, 0);
        b3 = '{0, 0};

        // Backpressure: result held for 5 cycles, then a one-cycle handoff to IDLE.
        beat(1, 4, -1);
        beat(2, 5, -1);
        out_ready = 1'b0;
        beat(3, 6, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", ov3, 1);
            check("bp_in_ready",  rdy3, 0);
            check("bp_S0",        s3_l[0], 32);
            check("bp_S1",        s3_l[1], -6);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_out_valid", ov3, 0);
        check("bp_release_in_ready",  rdy3, 1);
        check("bp_release_busy",      busy3, 0);
        @(posedge clk);
        #1;

        // Reset mid-vector discards the partial sum.
        beat(1, 4, -1);
        beat(2, 5, -1);
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", ov3, 0);
        check("rstmid_busy",      busy3, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b3 = '{7, 7};
        beat(1, 4, -1);
        beat(2, 5, -1);
        beat(3, 6, -1);
        expect_hold("rstmid", 39, 1, 39, 1);
        b3 = '{0, 0};

        // K=1 instance: single beat goes straight to HOLD.
        idle(3);
        b1 = '{2, 0};
        beat(5, -3, 4);
        @(negedge clk);
        check("k1_out_valid_lit", ov1, 1);
        check("k1_S0_lit",        s1_l[0], -13);
        check("k1_S1_lit",        s1_l[1], 20);
        @(posedge clk);
        #1;
        b1 = '{0, 0};
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised traffic with bubbles, backpressure, random biases and rare resets.
        for (int i = 0; i < 400; i++) begin
            x_in      = N'($urandom);
            w_in[0]   = N'($urandom);
            w_in[1]   = N'($urandom);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            for (int m = 0; m < M; m++) begin
                b3[m] = wrap(longint'(int'($urandom)), L3);
                b1[m] = wrap(longint'(int'($urandom)), L1);
            end
            rst_n = ($urandom_range(99) != 0);
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
